// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to packed BCD converter with overflow and leading-zero mask
module bin2bcd_seq #(
   parameter int IN_W   = 27,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [IN_W-1:0]       bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  ovf,
   output logic [DIGITS-1:0]     digit_nz
);
   localparam int CW = $clog2(IN_W + 1);
   localparam int SW = 4 * (DIGITS + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t              state_q, state_d;
   logic [IN_W-1:0]     sr_q, sr_d;
   logic [SW-1:0]       dig_q, dig_d, dig_adj;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d, res;
   logic                ovf_q, ovf_d, ovf_res, done_q, done_d;
   logic [DIGITS-1:0]   nz_q, nz_d, nz_res;
   logic [SW+IN_W-1:0]  shifted;
   logic                run;
   // one double-dabble step plus the result the step would publish if it is the last one
   always_comb begin
      dig_adj = '0;
      for (int i = 0; i < DIGITS + 1; i++)
         dig_adj[4*i+:4] = (dig_q[4*i+:4] >= 4'd5) ? dig_q[4*i+:4] + 4'd3 : dig_q[4*i+:4];
      shifted = {dig_adj[SW-2:0], sr_q, 1'b0};
      ovf_res = dig_adj[SW-1] | (|shifted[SW+IN_W-1 -: 4]);
      res     = ovf_res ? {DIGITS{4'h9}} : shifted[IN_W +: 4*DIGITS];
      run     = 1'b0;
      nz_res  = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         run       = run | (|res[4*i+:4]);
         nz_res[i] = run;
      end
      nz_res[0] = 1'b1;
   end
   // next-state and datapath update for IDLE -> SHIFT -> DONE
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      dig_d   = dig_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      nz_d    = nz_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            sr_d    = bin_in;
            dig_d   = '0;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            dig_d = shifted[SW+IN_W-1:IN_W];
            sr_d  = shifted[IN_W-1:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(IN_W - 1)) begin
               bcd_d   = res;
               ovf_d   = ovf_res;
               nz_d    = nz_res;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // state and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         sr_q    <= '0;
         dig_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         nz_q    <= DIGITS'(1);
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         dig_q   <= dig_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         nz_q    <= nz_d;
         done_q  <= done_d;
      end
   end
   assign busy     = (state_q == SHIFT);
   assign done     = done_q;
   assign bcd_out  = bcd_q;
   assign ovf      = ovf_q;
   assign digit_nz = nz_q;
endmodule
